// File: rtl/act_readout.sv
// ---------------------------------------------------------------------------
// act_readout
//
// Drains a layer's activation buffer once the layer controller has filled it.
// Each entry is read from the buffer, presented on a valid/ready stream with
// its index, and folded into a running signed argmax. For the output layer
// the argmax index is published as the classification result.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   start        one-cycle pulse, begins a readout (only honoured in IDLE)
//   layer_sel    sampled with start: 0 = hidden layer, 1 = output layer
//   act_re       buffer read enable (high only in FETCH)
//   act_raddr    buffer read address
//   act_rdata    buffer read data, valid the cycle after act_re
//   out_valid    stream data valid
//   out_ready    stream sink ready
//   out_data     activation value
//   out_idx      index of out_data
//   out_last     marks the final entry of the readout
//   busy         high in every state except IDLE
//   done         one-cycle pulse at the end of a readout
//   class_idx    argmax index of the output layer
//   class_valid  class_idx valid (held until the next accepted start)
// ---------------------------------------------------------------------------
module act_readout #(
  parameter int DATA_W = 16,
  parameter int HID_N  = 64,
  parameter int OUT_N  = 10,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              layer_sel,
  output logic              act_re,
  output logic [ADDR_W-1:0] act_raddr,
  input  logic [DATA_W-1:0] act_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [3:0]        class_idx,
  output logic              class_valid
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Index of the final entry for each layer; the readout stores the last
  // index rather than the length so the end test is a plain equality.
  localparam logic [ADDR_W-1:0] HID_LAST = ADDR_W'(HID_N - 1);
  localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_N - 1);

  logic [2:0]               state;
  logic [ADDR_W-1:0]        idx;
  logic [ADDR_W-1:0]        last_idx;
  logic                     sel_out;
  logic [DATA_W-1:0]        data_q;
  logic [ADDR_W-1:0]        idx_q;
  logic                     last_q;
  logic signed [DATA_W-1:0] max_val;
  // Only the output layer's argmax is ever published, and it has at most
  // 16 entries, so the tracked index is kept 4 bits wide. The hidden-layer
  // argmax is still computed but never exposed.
  logic [3:0]               max_idx;
  logic [3:0]               class_q;
  logic                     class_valid_q;
  logic                     busy_q;

  logic                     new_max;

  // Entry 0 seeds the running maximum unconditionally; afterwards only a
  // strictly greater value replaces it, so ties keep the lowest index.
  assign new_max = (idx == '0) || ($signed(act_rdata) > max_val);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      last_idx      <= '0;
      sel_out       <= 1'b0;
      data_q        <= '0;
      idx_q         <= '0;
      last_q        <= 1'b0;
      max_val       <= '0;
      max_idx       <= '0;
      class_q       <= '0;
      class_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            last_idx      <= layer_sel ? OUT_LAST : HID_LAST;
            sel_out       <= layer_sel;
            idx           <= '0;
            max_val       <= '0;
            max_idx       <= '0;
            class_valid_q <= 1'b0;
            busy_q        <= 1'b1;
            state         <= S_FETCH;
          end
        end

        S_FETCH: begin
          state <= S_LOAD;
        end

        S_LOAD: begin
          // Read data returned for the address issued in FETCH.
          data_q <= act_rdata;
          idx_q  <= idx;
          last_q <= (idx == last_idx);
          if (new_max) begin
            max_val <= $signed(act_rdata);
            max_idx <= idx[3:0];
          end
          state <= S_SEND;
        end

        S_SEND: begin
          // Stream fields were frozen in LOAD; they only change after the
          // sink accepts the beat.
          if (out_ready) begin
            if (last_q) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          if (sel_out) begin
            class_q       <= max_idx;
            class_valid_q <= 1'b1;
          end
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Address is forced to zero outside FETCH so the buffer port is quiet
  // whenever no read is being issued.
  assign act_re      = (state == S_FETCH);
  assign act_raddr   = act_re ? idx : '0;
  assign out_valid   = (state == S_SEND);
  assign out_data    = data_q;
  assign out_idx     = idx_q;
  assign out_last    = last_q;
  assign busy        = busy_q;
  assign done        = (state == S_DONE);
  assign class_idx   = class_q;
  assign class_valid = class_valid_q;

endmodule

// File: tb/tb_act_readout.sv
// ---------------------------------------------------------------------------
// tb_act_readout
//
// Directed bench for act_readout. A behavioural buffer model answers reads
// one cycle after act_re. Each scenario task drives its own stimulus and
// compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_act_readout;

  localparam int DATA_W = 16;
  localparam int HID_N  = 64;
  localparam int OUT_N  = 10;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst;
  logic              start;
  logic              layer_sel;
  logic              act_re;
  logic [ADDR_W-1:0] act_raddr;
  logic [DATA_W-1:0] act_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [3:0]        class_idx;
  logic              class_valid;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [DATA_W-1:0] mem [0:HID_N-1];

  // capture buffers filled by collect()
  logic [DATA_W-1:0] cap_data [0:HID_N-1];
  logic [ADDR_W-1:0] cap_idx  [0:HID_N-1];
  logic              cap_last [0:HID_N-1];
  int                cap_n;
  int                cap_first_wait;
  logic              cap_to;
  logic              cap_done;

  act_readout #(
    .DATA_W(DATA_W), .HID_N(HID_N), .OUT_N(OUT_N), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel),
    .act_re(act_re), .act_raddr(act_raddr), .act_rdata(act_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done),
    .class_idx(class_idx), .class_valid(class_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // buffer model: registered read
  always @(posedge clk) begin
    if (act_re) act_rdata <= mem[act_raddr];
  end

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic sel);
    start     = 1'b1;
    layer_sel = sel;
    @(posedge clk); #1;
    start     = 1'b0;
    layer_sel = 1'b0;
  endtask

  // Accepts n beats with out_ready held high, recording each one.
  task automatic collect(input int n);
    int w;
    cap_n = 0; cap_to = 1'b0; cap_first_wait = -1; cap_done = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (out_valid !== 1'b1 && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      if (out_valid !== 1'b1) begin
        cap_to = 1'b1;
        return;
      end
      if (k == 0) cap_first_wait = w;
      cap_data[k] = out_data;
      cap_idx[k]  = out_idx;
      cap_last[k] = out_last;
      cap_n++;
      @(posedge clk); #1;
    end
    cap_done = done;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (act_re !== 1'b0) begin failures++; $display("FAIL reset_act_re: got %b expected 0", act_re); end
    checks++; if (act_raddr !== '0) begin failures++; $display("FAIL reset_act_raddr: got %0d expected 0", act_raddr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    checks++; if (out_idx !== '0 || out_last !== 1'b0) begin failures++; $display("FAIL reset_out_idx_last: got %0d/%b expected 0/0", out_idx, out_last); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done: got %b/%b expected 0/0", busy, done); end
    checks++; if (class_idx !== 4'd0 || class_valid !== 1'b0) begin failures++; $display("FAIL reset_class: got %0d/%b expected 0/0", class_idx, class_valid); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_hidden();
    int bad;
    for (int i = 0; i < HID_N; i++) mem[i] = 16'(i * 3);
    do_start(1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hid_busy: got %b expected 1", busy); end
    collect(HID_N);
    checks++; if (cap_to !== 1'b0 || cap_n != HID_N) begin failures++; $display("FAIL hid_count: got %0d beats expected %0d", cap_n, HID_N); end
    checks++; if (cap_first_wait != 2) begin failures++; $display("FAIL hid_latency: got %0d expected 2", cap_first_wait); end
    bad = 0;
    for (int i = 0; i < cap_n; i++) begin
      checks++;
      if (cap_data[i] !== 16'(i * 3) || cap_idx[i] !== 6'(i) || cap_last[i] !== (i == HID_N - 1)) begin
        failures++; bad++;
        if (bad < 4) $display("FAIL hid_beat%0d: got data=%0d idx=%0d last=%b expected data=%0d idx=%0d last=%b",
                              i, cap_data[i], cap_idx[i], cap_last[i], i * 3, i, (i == HID_N - 1));
      end
    end
    checks++; if (cap_done !== 1'b1) begin failures++; $display("FAIL hid_done: got %b expected 1", cap_done); end
    @(posedge clk); #1;
    checks++; if (class_valid !== 1'b0) begin failures++; $display("FAIL hid_class_valid: got %b expected 0", class_valid); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL hid_idle: got busy=%b done=%b expected 0/0", busy, done); end
    $display("test_hidden done: %0d beats", cap_n);
  endtask

  task automatic test_argmax();
    logic [DATA_W-1:0] v [0:9];
    v = '{16'hFFFB, 16'd7, 16'd2, 16'd7, 16'hFF9C, 16'd0, 16'd6, 16'd1, 16'd3, 16'hFFFF};
    for (int i = 0; i < OUT_N; i++) mem[i] = v[i];
    do_start(1'b1);
    collect(OUT_N);
    checks++; if (cap_to !== 1'b0 || cap_n != OUT_N) begin failures++; $display("FAIL argmax_count: got %0d expected %0d", cap_n, OUT_N); end
    for (int i = 0; i < cap_n; i++) begin
      checks++;
      if (cap_data[i] !== v[i] || cap_idx[i] !== 6'(i) || cap_last[i] !== (i == OUT_N - 1)) begin
        failures++;
        $display("FAIL argmax_beat%0d: got data=%0h idx=%0d last=%b expected data=%0h idx=%0d", i, cap_data[i], cap_idx[i], cap_last[i], v[i], i);
      end
    end
    checks++; if (cap_done !== 1'b1) begin failures++; $display("FAIL argmax_done: got %b expected 1", cap_done); end
    @(posedge clk); #1;
    checks++; if (class_valid !== 1'b1 || class_idx !== 4'd1) begin failures++; $display("FAIL argmax_class: got idx=%0d valid=%b expected 1/1", class_idx, class_valid); end
    $display("test_argmax done: class_idx=%0d", class_idx);
  endtask

  task automatic test_all_negative();
    logic [DATA_W-1:0] v [0:9];
    // -8,-3,-9,-4,-10,-5,-3,-20,-7,-6 : maximum -3 first at index 1
    v = '{16'hFFF8, 16'hFFFD, 16'hFFF7, 16'hFFFC, 16'hFFF6, 16'hFFFB, 16'hFFFD, 16'hFFEC, 16'hFFF9, 16'hFFFA};
    for (int i = 0; i < OUT_N; i++) mem[i] = v[i];
    do_start(1'b1);
    checks++; if (class_valid !== 1'b0) begin failures++; $display("FAIL neg_class_clear: got %b expected 0", class_valid); end
    collect(OUT_N);
    checks++; if (cap_to !== 1'b0 || cap_n != OUT_N || cap_done !== 1'b1) begin failures++; $display("FAIL neg_count: got %0d done=%b expected %0d done=1", cap_n, cap_done, OUT_N); end
    @(posedge clk); #1;
    checks++; if (class_valid !== 1'b1 || class_idx !== 4'd1) begin failures++; $display("FAIL neg_class: got idx=%0d valid=%b expected 1/1", class_idx, class_valid); end
    $display("test_all_negative done: class_idx=%0d", class_idx);
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] held;
    int w;
    for (int i = 0; i < OUT_N; i++) mem[i] = 16'(i * 11 - 20);
    do_start(1'b1);
    collect(4);
    out_ready = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    checks++; if (out_valid !== 1'b1 || out_idx !== 6'd4 || out_data !== 16'd24) begin failures++; $display("FAIL bp_entry4: got valid=%b idx=%0d data=%0d expected 1/4/24", out_valid, out_idx, out_data); end
    held = out_data;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 6'd4 || out_data !== held || act_re !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: got valid=%b idx=%0d data=%0d act_re=%b expected 1/4/%0d/0", c, out_valid, out_idx, out_data, act_re, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (act_re !== 1'b1 || act_raddr !== 6'd5 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_resume_fetch: got re=%b addr=%0d valid=%b expected 1/5/0", act_re, act_raddr, out_valid); end
    collect(5);
    checks++; if (cap_n != 5 || cap_idx[0] !== 6'd5 || cap_data[0] !== 16'd35) begin failures++; $display("FAIL bp_resume_beat: got n=%0d idx=%0d data=%0d expected 5/5/35", cap_n, cap_idx[0], cap_data[0]); end
    checks++; if (cap_last[4] !== 1'b1 || cap_done !== 1'b1) begin failures++; $display("FAIL bp_end: got last=%b done=%b expected 1/1", cap_last[4], cap_done); end
    @(posedge clk); #1;
    checks++; if (class_idx !== 4'd9 || class_valid !== 1'b1) begin failures++; $display("FAIL bp_class: got %0d/%b expected 9/1", class_idx, class_valid); end
    $display("test_backpressure done");
  endtask

  task automatic test_start_busy();
    for (int i = 0; i < HID_N; i++) mem[i] = 16'(i * 3);
    do_start(1'b0);
    collect(20);
    // spurious start, requesting the output layer, in the middle of the run
    do_start(1'b1);
    collect(HID_N - 20);
    checks++; if (cap_to !== 1'b0 || cap_n != HID_N - 20) begin failures++; $display("FAIL sb_count: got %0d expected %0d", cap_n, HID_N - 20); end
    checks++; if (cap_idx[0] !== 6'd20 || cap_data[0] !== 16'd60) begin failures++; $display("FAIL sb_first: got idx=%0d data=%0d expected 20/60", cap_idx[0], cap_data[0]); end
    checks++; if (cap_idx[43] !== 6'd63 || cap_last[43] !== 1'b1 || cap_data[43] !== 16'd189) begin failures++; $display("FAIL sb_last: got idx=%0d last=%b data=%0d expected 63/1/189", cap_idx[43], cap_last[43], cap_data[43]); end
    checks++; if (cap_done !== 1'b1) begin failures++; $display("FAIL sb_done: got %b expected 1", cap_done); end
    @(posedge clk); #1;
    checks++; if (class_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL sb_class: got valid=%b busy=%b expected 0/0", class_valid, busy); end
    $display("test_start_busy done");
  endtask

  task automatic test_reset_mid();
    int w;
    int dc;
    for (int i = 0; i < HID_N; i++) mem[i] = 16'(i * 3);
    do_start(1'b0);
    collect(30);
    out_ready = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    checks++; if (out_valid !== 1'b1 || out_idx !== 6'd30) begin failures++; $display("FAIL rm_at30: got valid=%b idx=%0d expected 1/30", out_valid, out_idx); end
    dc = done_cnt;
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== '0 || out_last !== 1'b0) begin failures++; $display("FAIL rm_out_clear: got valid=%b data=%0d idx=%0d last=%b expected all 0", out_valid, out_data, out_idx, out_last); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || act_re !== 1'b0 || act_raddr !== '0) begin failures++; $display("FAIL rm_ctrl_clear: got busy=%b done=%b re=%b addr=%0d expected all 0", busy, done, act_re, act_raddr); end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done_cnt != dc || busy !== 1'b0) begin failures++; $display("FAIL rm_no_done: got done pulses=%0d busy=%b expected %0d/0", done_cnt, busy, dc); end
    do_start(1'b0);
    collect(3);
    checks++; if (cap_n != 3 || cap_idx[0] !== 6'd0 || cap_data[0] !== 16'd0 || cap_idx[2] !== 6'd2 || cap_data[2] !== 16'd6) begin
      failures++; $display("FAIL rm_restart: got n=%0d idx0=%0d data0=%0d idx2=%0d data2=%0d expected 3/0/0/2/6", cap_n, cap_idx[0], cap_data[0], cap_idx[2], cap_data[2]);
    end
    collect(HID_N - 3);
    checks++; if (cap_done !== 1'b1 || cap_idx[HID_N-4] !== 6'd63) begin failures++; $display("FAIL rm_finish: got done=%b idx=%0d expected 1/63", cap_done, cap_idx[HID_N-4]); end
    @(posedge clk); #1;
    $display("test_reset_mid done");
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    layer_sel = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_hidden();
    test_argmax();
    test_all_negative();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
